// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter producing open-drain line enables
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES       = 10000,
    parameter int START_TIMEOUT_CYCLES = 1500000,
    parameter int BIT_TIMEOUT_CYCLES   = 200000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       rx_inhibit,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code
);
    localparam int CW = $clog2(START_TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] START_MAX = CW'(START_TIMEOUT_CYCLES);
    localparam logic [CW-1:0] BIT_MAX   = CW'(BIT_TIMEOUT_CYCLES);

    typedef enum logic [3:0] {IDLE, INHIBIT, REQ, WAIT_FIRST, SEND, ACK, WAIT_IDLE, DONE, FAIL} state_t;

    state_t        state;
    logic [2:0]    clk_sync;
    logic [1:0]    data_sync;
    logic [9:0]    frame;
    logic [3:0]    idx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          sync_clk;
    logic          sync_data;
    logic          fe;
    logic          accept;
    logic          tmo;
    logic          bus_idle;
    logic [1:0]    fail_code;

    assign sync_clk   = clk_sync[1];
    assign sync_data  = data_sync[1];
    assign fe         = ~clk_sync[1] & clk_sync[2];
    assign bus_idle   = sync_clk & sync_data;
    assign tx_ready   = state == IDLE;
    assign busy       = ~tx_ready;
    assign rx_inhibit = busy;
    assign accept     = tx_valid & tx_ready;
    assign cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;
    assign tmo        = cnt >= ((state == WAIT_FIRST) ? START_MAX : BIT_MAX);
    assign fail_code  = (state == WAIT_FIRST && !fe && tmo) ? 2'b01 :
                        (state == ACK && fe && sync_data) ? 2'b11 :
                        (((state == SEND || state == ACK) && !fe && tmo) ||
                         (state == WAIT_IDLE && !bus_idle && tmo)) ? 2'b10 : 2'b00;

    // Bring the asynchronous lines into the clock domain; idle-high reset avoids a false edge
    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync  <= 3'b111;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    // Frame sequencer with registered line enables and one-cycle done/err strobes
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            err_code    <= 2'b00;
            frame       <= '0;
            idx         <= '0;
            cnt         <= '0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            cnt     <= cnt_inc;
            if (fail_code != 2'b00) begin
                state       <= FAIL;
                tx_err      <= 1'b1;
                err_code    <= fail_code;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        frame      <= {1'b1, ~^tx_data, tx_data};
                        err_code   <= 2'b00;
                        cnt        <= '0;
                        idx        <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= INHIBIT;
                    end
                    INHIBIT: if (cnt == INH_LAST) begin
                        ps2_data_oe <= 1'b1;
                        state       <= REQ;
                    end
                    REQ: begin
                        ps2_clk_oe <= 1'b0;
                        cnt        <= '0;
                        state      <= WAIT_FIRST;
                    end
                    WAIT_FIRST: if (fe) begin
                        ps2_data_oe <= ~frame[0];
                        idx         <= 4'd1;
                        cnt         <= '0;
                        state       <= SEND;
                    end
                    SEND: if (fe) begin
                        ps2_data_oe <= ~frame[idx];
                        idx         <= idx + 4'd1;
                        cnt         <= '0;
                        state       <= (idx == 4'd9) ? ACK : SEND;
                    end
                    ACK: if (fe) begin
                        cnt   <= '0;
                        state <= WAIT_IDLE;
                    end
                    WAIT_IDLE: if (bus_idle) begin
                        tx_done <= 1'b1;
                        state   <= DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
